// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared FSM state type and sizing constants for the tick generator
package tick_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int DIV_W_DEF = 26;
    localparam int MIN_DIV   = 2;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: modulo-divisor cycle counter emitting a registered one-cycle tick on wrap
module tick_prescaler
    import tick_gen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             hold,
    input  logic             clr,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);

    logic [DIV_W-1:0] count;
    logic             adv;
    logic             wrap;

    assign adv  = inc && !hold;
    assign wrap = count == divisor - DIV_W'(1);

    // count advances only when enabled and not held; tick marks the wrap edge
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            count <= adv ? (wrap ? '0 : count + DIV_W'(1)) : count;
            tick  <= adv && wrap;
        end
    end

endmodule

// File: rtl/tick_gen_ctrl.sv
// tick_gen_ctrl: run/pause/clear controller around a tick prescaler (optional TICK_DIV_LOAD_EN)
module tick_gen_ctrl
    import tick_gen_pkg::*;
#(
    parameter int DIV   = 50000000,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_stop,
    input  logic             clear,
`ifdef TICK_DIV_LOAD_EN
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    output logic             load_err,
`endif
    output logic             tick,
    output logic             running,
    output logic             sec_clr
);

    localparam logic [DIV_W-1:0] DIV_V = DIV_W'(DIV);

    state_t           st;
    state_t           nxt;
    logic             inc;
    logic             hold;
    logic             clr;
    logic [DIV_W-1:0] divisor;

    // state register
    always_ff @(posedge clk) begin
        st <= rst ? IDLE : nxt;
    end

    // next state and prescaler controls; clear dominates start_stop
    always_comb begin
        nxt  = st;
        nxt  = clear ? IDLE : start_stop ? ((st == RUN) ? PAUSE : RUN) : st;
        inc  = (st != IDLE) && !clear;
        hold = st == PAUSE;
        clr  = clear || st == IDLE;
    end

    // registered status outputs; running trails the state by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            sec_clr <= 1'b0;
        end else begin
            running <= st == RUN;
            sec_clr <= clear;
        end
    end

`ifdef TICK_DIV_LOAD_EN
    logic ld_ok;

    assign ld_ok = div_load && !clear && st == IDLE && div_value >= DIV_W'(MIN_DIV);

    // divisor reload only while idle; bad or mistimed loads flag load_err
    always_ff @(posedge clk) begin
        if (rst) begin
            divisor  <= DIV_V;
            load_err <= 1'b0;
        end else begin
            divisor  <= ld_ok ? div_value : divisor;
            load_err <= div_load && !clear && !ld_ok;
        end
    end
`else
    assign divisor = DIV_V;
`endif

    tick_prescaler #(.DIV_W(DIV_W)) u_pre (
        .clk     (clk),
        .rst     (rst),
        .inc     (inc),
        .hold    (hold),
        .clr     (clr),
        .divisor (divisor),
        .tick    (tick)
    );

endmodule

// File: doc/tick_gen_ctrl.md
TICK_GEN_CTRL -- requirements
Module: tick_gen_ctrl

Interface
REQ-001 Parameter: DIV, default 50000000, clock cycles per output tick (legal range 2 to 2^DIV_W-1).
REQ-002 Parameter: DIV_W, default 26, width of prescaler count and divisor.
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: start_stop  in  1  one-cycle pulse; toggles run/pause.
REQ-006 Port: clear  in  1  one-cycle pulse; abort to idle and clear downstream.
REQ-007 Port: tick  out  1  one-cycle enable pulse to downstream seconds counter.
REQ-008 Port: running  out  1  high while state is RUN.
REQ-009 Port: sec_clr  out  1  one-cycle clear pulse to downstream counter.
REQ-010 Ports (DIV_LOAD_EN only): div_load in 1 pulse; div_value in DIV_W new divisor; load_err out 1 rejected-load pulse.

Function
REQ-011 FSM states SHALL be IDLE, RUN, PAUSE; all outputs registered.
REQ-012 IDLE: prescaler count held at 0, tick 0; start_stop -> RUN.
REQ-013 RUN: count increments by 1 per cycle; at count == divisor-1 it wraps to 0 and tick is 1 in the following cycle only.
REQ-014 First tick SHALL appear exactly divisor cycles after the edge entering RUN; subsequent tick period exactly divisor cycles.
REQ-015 RUN with start_stop -> PAUSE; count does not advance and no tick is produced from that cycle.
REQ-016 PAUSE: count retained; start_stop -> RUN, counting resumes from the retained value (no phase loss).
REQ-017 clear in any state -> IDLE, count 0, tick 0, sec_clr 1 in the next cycle for one cycle.
REQ-018 clear and start_stop in the same cycle: clear wins, start_stop ignored.
REQ-019 running SHALL equal (state == RUN) one cycle after the transition edge, never combinational.
REQ-020 div_load accepted only in IDLE with div_value >= 2; divisor updated next cycle.
REQ-021 div_load in RUN/PAUSE, or div_value < 2: divisor unchanged, load_err 1 for one cycle.
REQ-022 div_load with clear in same cycle: clear processed, load ignored, no load_err.
REQ-023 Count arithmetic SHALL be DIV_W bits unsigned; count never reaches divisor.

Reset
REQ-024 rst SHALL force IDLE, count 0, divisor = DIV, tick 0, running 0, sec_clr 0, load_err 0.
REQ-025 rst asserted mid-RUN or mid-PAUSE SHALL discard retained count; rst dominates all inputs.

Configuration
REQ-026 Macro TICK_DIV_LOAD_EN defined: REQ-010, REQ-020..022 present; divisor runtime-loadable.
REQ-027 Macro TICK_DIV_LOAD_EN undefined: div_load/div_value/load_err ports absent; divisor constant DIV.

Structure
REQ-028 Package tick_gen_pkg SHALL hold the state enum (IDLE/RUN/PAUSE), DIV_W default and MIN_DIV = 2.
REQ-029 Sub-module tick_prescaler SHALL hold the count register, wrap compare and tick register, with inc/hold/clr controls driven by the FSM.

Verification (DIV=4)
REQ-030 Reset then start_stop at cycle 0 -> tick high at cycles 4, 8, 12 only; running high from cycle 1.
REQ-031 start_stop at cycles 0 and 6, again at 10 -> tick at 4, then next at 12 (count 2 retained over pause).
REQ-032 Run 5 cycles, clear plus start_stop same cycle -> IDLE, sec_clr one-cycle pulse, running 0, no tick thereafter.
REQ-033 TICK_DIV_LOAD_EN: div_load value 3 in IDLE, start -> ticks every 3 cycles; load value 1 -> load_err pulse, divisor stays 3.
REQ-034 TICK_DIV_LOAD_EN: div_load during RUN -> load_err pulse, tick period unchanged at 4.
REQ-035 rst at cycle 6 of RUN -> all outputs 0 next cycle; subsequent start_stop gives first tick 4 cycles after entering RUN.
